// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: word type, round constants and the sigma/choice/majority helpers.
// Used by both the message scheduler and the compression round engine.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int SHA256_ROUNDS = 64;
  localparam int WIN_WORDS     = 16;
  localparam int BLK_BITS      = 512;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message-schedule sigmas (lower-case sigma in FIPS 180-4).
  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Compression-round sigmas (upper-case Sigma).
  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_msg_sched_if.sv
// Block-in / W-word-out bundle between the block buffer, the message scheduler and the round engine.
// master = scheduler side, slave = the surrounding producer/consumer pair.
interface sha256_msg_sched_if;
  import sha256_pkg::*;

  logic                blk_valid;
  logic                blk_ready;
  logic [BLK_BITS-1:0] blk_data;
  logic                w_valid;
  logic                w_ready;
  word_t               w_data;
  logic [5:0]          w_idx;
  logic                w_last;
  logic                busy;

  modport master (
    input  blk_valid, blk_data, w_ready,
    output blk_ready, w_valid, w_data, w_idx, w_last, busy
  );

  modport slave (
    output blk_valid, blk_data, w_ready,
    input  blk_ready, w_valid, w_data, w_idx, w_last, busy
  );

endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads a 512-bit block, streams W[0..ROUNDS-1] one word per handshake.
// First word the cycle after accept; w_ready low freezes window and outputs; optional same-cycle preload.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int ROUNDS        = SHA256_ROUNDS,
  parameter bit ALLOW_PRELOAD = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  sha256_msg_sched_if.master bus
);

  if (ROUNDS < 16 || ROUNDS > SHA256_ROUNDS) begin : g_bad_rounds
    $error("sha256_msg_sched: ROUNDS must be within 16..64");
  end

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  sched_state_t r_state;
  sched_state_t w_state_nxt;
  word_t        r_win [WIN_WORDS];
  logic [5:0]   r_idx;

  logic  w_run;
  logic  w_hs;
  logic  w_last_hs;
  logic  w_blk_rdy;
  logic  w_load;
  logic  w_valid;
  logic  w_last;
  logic  w_busy;
  word_t w_new_word;

  assign w_run      = (r_state == ST_RUN);
  assign w_hs       = w_run & bus.w_ready;
  assign w_last_hs  = w_hs & (r_idx == LAST_IDX);
  assign w_load     = bus.blk_valid & w_blk_rdy;
  // Produces W[t+16] from the window holding W[t..t+15].
  assign w_new_word = ssig1(r_win[14]) + r_win[9] + ssig0(r_win[1]) + r_win[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last_hs && !w_load) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_blk_rdy = 1'b0;
    w_valid   = 1'b0;
    w_last    = 1'b0;
    w_busy    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_blk_rdy = 1'b1;
      end
      ST_RUN: begin
        w_valid   = 1'b1;
        w_busy    = 1'b1;
        w_last    = (r_idx == LAST_IDX);
        // Only the final word's handshake may overlap with the next block load.
        w_blk_rdy = ALLOW_PRELOAD & w_last_hs;
      end
      default: begin
        w_blk_rdy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIN_WORDS; i++) begin
        r_win[i] <= '0;
      end
      r_idx <= '0;
    end else if (w_load) begin
      for (int i = 0; i < WIN_WORDS; i++) begin
        r_win[i] <= bus.blk_data[BLK_BITS-1-32*i -: 32];
      end
      r_idx <= '0;
    end else if (w_hs) begin
      for (int i = 0; i < WIN_WORDS - 1; i++) begin
        r_win[i] <= r_win[i+1];
      end
      r_win[WIN_WORDS-1] <= w_new_word;
      r_idx              <= r_idx + 6'd1;
    end
  end

  assign bus.blk_ready = w_blk_rdy;
  assign bus.w_valid   = w_valid;
  assign bus.w_data    = r_win[0];
  assign bus.w_idx     = r_idx;
  assign bus.w_last    = w_last;
  assign bus.busy      = w_busy;

endmodule
